// File: rtl/prefetch_arbiter.sv
// Round-robin arbiter sharing one next-line prefetcher lookup port among NUM_CORES
// cores. It keeps saturating per-core hit/miss counters and aborts a lookup that gets no response.
module prefetch_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CORES-1:0]       req,
  input  logic [32*NUM_CORES-1:0]    req_addr,
  output logic [NUM_CORES-1:0]       ack,
  output logic                       resp_hit,
  output logic                       resp_err,
  output logic                       busy,
  output logic [31:0]                pf_address,
  output logic                       pf_cache_miss,
  input  logic                       pf_prefetch_hit,
  input  logic                       pf_prefetch_miss,
  output logic [CNT_W*NUM_CORES-1:0] hit_count,
  output logic [CNT_W*NUM_CORES-1:0] miss_count
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, WAIT_CLR, RESP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     cur_core_q, cur_core_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]       addr_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic              result_hit_q, result_hit_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  hit_q  [NUM_CORES];
  logic [CNT_W-1:0]  hit_d  [NUM_CORES];
  logic [CNT_W-1:0]  miss_q [NUM_CORES];
  logic [CNT_W-1:0]  miss_d [NUM_CORES];
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;
  logic [NUM_CORES-1:0] ack_d;

  // First requesting core at or after rr_ptr, wrapping to core 0.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_core_d   = cur_core_q;
    rr_ptr_d     = rr_ptr_q;
    addr_d       = pf_address;
    tcnt_d       = tcnt_q;
    result_hit_d = result_hit_q;
    err_d        = err_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          cur_core_d = grant_idx;
          addr_d     = req_addr[32*grant_idx +: 32];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_d  = 8'd0;
        state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (pf_prefetch_hit || pf_prefetch_miss) begin
          // A double response counts as a hit but is flagged as an error.
          result_hit_d = pf_prefetch_hit;
          err_d        = pf_prefetch_hit && pf_prefetch_miss;
          if (pf_prefetch_hit) begin
            if (hit_q[cur_core_q] != CNT_MAX)
              hit_d[cur_core_q] = hit_q[cur_core_q] + CNT_W'(1);
          end else begin
            if (miss_q[cur_core_q] != CNT_MAX)
              miss_d[cur_core_q] = miss_q[cur_core_q] + CNT_W'(1);
          end
          state_d = WAIT_CLR;
        end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
          err_d        = 1'b1;
          result_hit_d = 1'b0;
          state_d      = RESP;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      WAIT_CLR: begin
        if (!pf_prefetch_hit && !pf_prefetch_miss) state_d = RESP;
      end
      RESP: begin
        rr_ptr_d     = (cur_core_q == IW'(NUM_CORES - 1)) ? '0 : cur_core_q + 1'b1;
        err_d        = 1'b0;
        result_hit_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    ack_d = '0;
    if (state_d == RESP) ack_d[cur_core_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_core_q    <= '0;
      rr_ptr_q      <= '0;
      pf_address    <= '0;
      tcnt_q        <= '0;
      result_hit_q  <= 1'b0;
      err_q         <= 1'b0;
      ack           <= '0;
      resp_hit      <= 1'b0;
      resp_err      <= 1'b0;
      busy          <= 1'b0;
      pf_cache_miss <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        hit_q[i]  <= '0;
        miss_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cur_core_q    <= cur_core_d;
      rr_ptr_q      <= rr_ptr_d;
      pf_address    <= addr_d;
      tcnt_q        <= tcnt_d;
      result_hit_q  <= result_hit_d;
      err_q         <= err_d;
      ack           <= ack_d;
      resp_hit      <= (state_d == RESP) && result_hit_d;
      resp_err      <= (state_d == RESP) && err_d;
      busy          <= (state_d != IDLE);
      pf_cache_miss <= (state_d == ISSUE);
      hit_q         <= hit_d;
      miss_q        <= miss_d;
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
    assign hit_count[CNT_W*g +: CNT_W]  = hit_q[g];
    assign miss_count[CNT_W*g +: CNT_W] = miss_q[g];
  end

endmodule

// File: tb/tb_prefetch_arbiter.sv
// Directed bench for prefetch_arbiter: 4 cores, 2-bit counters, TIMEOUT 15.
module tb_prefetch_arbiter;

  localparam int NC = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   req;
  logic [32*NC-1:0] req_addr;
  logic [NC-1:0]   ack;
  logic            resp_hit, resp_err, busy, pf_cache_miss;
  logic [31:0]     pf_address;
  logic            pf_prefetch_hit, pf_prefetch_miss;
  logic [CW*NC-1:0] hit_count, miss_count;

  int errors = 0;
  int checks = 0;
  int exp_hit[NC];
  int exp_miss[NC];
  logic [31:0] addr_of[NC];

  prefetch_arbiter #(.NUM_CORES(NC), .CNT_W(CW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .ack(ack),
    .resp_hit(resp_hit), .resp_err(resp_err), .busy(busy),
    .pf_address(pf_address), .pf_cache_miss(pf_cache_miss),
    .pf_prefetch_hit(pf_prefetch_hit), .pf_prefetch_miss(pf_prefetch_miss),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("%s_hit%0d", tag, c), 64'(hit_count[CW*c +: CW]), 64'(exp_hit[c]));
      check($sformatf("%s_miss%0d", tag, c), 64'(miss_count[CW*c +: CW]), 64'(exp_miss[c]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    pf_prefetch_hit  = 1'b0;
    pf_prefetch_miss = 1'b0;
    for (int c = 0; c < NC; c++) begin
      exp_hit[c]  = 0;
      exp_miss[c] = 0;
    end
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_strobe", pf_cache_miss, 0);
    check("rst_addr", pf_address, 0);
    check("rst_resp", {resp_hit, resp_err}, 0);
    check_counts("rst");
    rst = 1'b0;
  endtask

  // Entered in IDLE just after a posedge with req already driven; leaves in IDLE.
  task automatic run_txn(input int core, input logic hit, input logic miss, input int clr_hold);
    logic exp_rh, exp_re;
    step();
    check("strobe", pf_cache_miss, 1);
    check("busy", busy, 1);
    check("pf_addr", pf_address, addr_of[core]);
    step();
    check("strobe_once", pf_cache_miss, 0);
    if (!hit && !miss) begin
      for (int i = 0; i < 14; i++) begin
        step();
        check("tmo_wait", {ack, busy}, {4'b0000, 1'b1});
      end
      step();
      exp_rh = 1'b0;
      exp_re = 1'b1;
    end else begin
      pf_prefetch_hit  = hit;
      pf_prefetch_miss = miss;
      step();
      if (hit) exp_hit[core] = (exp_hit[core] == 3) ? 3 : exp_hit[core] + 1;
      else exp_miss[core] = (exp_miss[core] == 3) ? 3 : exp_miss[core] + 1;
      for (int i = 0; i < clr_hold; i++) begin
        check("clr_hold", {ack, pf_cache_miss}, 0);
        step();
      end
      pf_prefetch_hit  = 1'b0;
      pf_prefetch_miss = 1'b0;
      step();
      exp_rh = hit;
      exp_re = hit && miss;
    end
    check("ack", ack, 4'b0001 << core);
    check("resp_hit", resp_hit, exp_rh);
    check("resp_err", resp_err, exp_re);
    check("addr_hold", pf_address, addr_of[core]);
    check_counts("cnt");
    req[core] = 1'b0;
    step();
    check("ack_clear", {ack, resp_hit, resp_err}, 0);
    check("idle", busy, 0);
  endtask

  initial begin
    for (int c = 0; c < NC; c++) addr_of[c] = 32'h1000_0000 + 32'(c) * 32'h100;
    addr_of[1] = 32'h0000_1230;
    req_addr = '0;
    for (int c = 0; c < NC; c++) req_addr[32*c +: 32] = addr_of[c];

    // Reset state, then a request held during reset must not be granted early.
    do_reset();
    rst = 1'b1;
    req = 4'b0010;
    step();
    check("no_grant_in_rst", busy, 0);
    rst = 1'b0;
    run_txn(1, 1'b0, 1'b1, 0);
    check("single_miss1", 64'(miss_count[CW*1 +: CW]), 1);

    // Fairness: all four request, each re-requests after its ack.
    do_reset();
    req = 4'b1111;
    run_txn(0, 1'b1, 1'b0, 0);
    req[0] = 1'b1;
    run_txn(1, 1'b0, 1'b1, 1);
    req[1] = 1'b1;
    run_txn(2, 1'b1, 1'b0, 2);
    req[2] = 1'b1;
    run_txn(3, 1'b0, 1'b1, 0);
    req[3] = 1'b1;
    for (int c = 0; c < NC; c++)
      check($sformatf("fair_total%0d", c),
            64'(hit_count[CW*c +: CW]) + 64'(miss_count[CW*c +: CW]), 1);
    run_txn(0, 1'b0, 1'b1, 0);
    req = '0;

    // Protocol violation on core 2: counts as a hit, flagged as error.
    req = 4'b0100;
    run_txn(2, 1'b1, 1'b1, 1);
    check("viol_hit2", 64'(hit_count[CW*2 +: CW]), 2);

    // Timeout on core 3: counters must not move.
    req = 4'b1000;
    run_txn(3, 1'b0, 1'b0, 0);
    check("tmo_miss3", 64'(miss_count[CW*3 +: CW]), 1);

    // Saturation of the 2-bit hit counter on core 0.
    do_reset();
    for (int n = 0; n < 5; n++) begin
      req = 4'b0001;
      run_txn(0, 1'b1, 1'b0, 0);
    end
    check("sat_hit0", 64'(hit_count[CW*0 +: CW]), 3);

    // Asynchronous reset while in WAIT_CLR, then arbitration restarts at core 0.
    req = 4'b0010;
    step();
    step();
    pf_prefetch_hit = 1'b1;
    step();
    check("pre_rst_hit1", 64'(hit_count[CW*1 +: CW]), 1);
    check("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_cnt", {hit_count, miss_count}, 0);
    check("async_ack", ack, 0);
    pf_prefetch_hit = 1'b0;
    req = '0;
    for (int c = 0; c < NC; c++) begin
      exp_hit[c]  = 0;
      exp_miss[c] = 0;
    end
    step();
    check("rst_hold_ack", ack, 0);
    rst = 1'b0;
    req = 4'b1001;
    run_txn(0, 1'b0, 1'b1, 0);
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prefetch_arbiter.md
PREFETCH_ARBITER -- requirements
Module: prefetch_arbiter

Interface
REQ-001: Parameter NUM_CORES, default 4: number of requesting cores, 2..8.
REQ-002: Parameter CNT_W, default 16: width of each per-core hit/miss counter.
REQ-003: Parameter TIMEOUT, default 15: maximum cycles spent in WAIT_RESP before abort, 1..255.
REQ-004: clk  input  1  single clock; all state updates on posedge clk.
REQ-005: rst  input  1  reset, asynchronous and active-high.
REQ-006: req  input  NUM_CORES  per-core lookup request on cache miss; held high until ack is sampled.
REQ-007: req_addr  input  32*NUM_CORES  per-core miss address; core i occupies bits [32*i+31:32*i]; stable while req[i] is high.
REQ-008: ack  output  NUM_CORES  one-cycle completion pulse to the granted core.
REQ-009: resp_hit  output  1  valid with ack; 1 means prefetch buffer hit.
REQ-010: resp_err  output  1  valid with ack; 1 means timeout or protocol violation.
REQ-011: busy  output  1  high in every state except IDLE.
REQ-012: pf_address  output  32  address driven to the shared next-line prefetcher.
REQ-013: pf_cache_miss  output  1  lookup strobe to the prefetcher.
REQ-014: pf_prefetch_hit  input  1  prefetcher hit result.
REQ-015: pf_prefetch_miss  input  1  prefetcher miss result.
REQ-016: hit_count  output  CNT_W*NUM_CORES  per-core prefetch hit counters, same packing as req_addr.
REQ-017: miss_count  output  CNT_W*NUM_CORES  per-core prefetch miss counters, same packing.

Function
REQ-018: FSM states: IDLE, ISSUE, WAIT_RESP, WAIT_CLR, RESP; all outputs registered.
REQ-019: IDLE: if any req bit is high, grant the first set bit at or after rr_ptr (round-robin, wrapping NUM_CORES-1 -> 0), latch its address into pf_address and its index into cur_core, then -> ISSUE; otherwise stay.
REQ-020: ISSUE: pf_cache_miss = 1 for exactly this one cycle; clear the timeout counter; -> WAIT_RESP.
REQ-021: pf_address holds the latched value from ISSUE through RESP inclusive.
REQ-022: WAIT_RESP: on pf_prefetch_hit or pf_prefetch_miss high, capture result_hit = pf_prefetch_hit and update the counter of cur_core (hit or miss), then -> WAIT_CLR.
REQ-023: Both pf_prefetch_hit and pf_prefetch_miss high in the same cycle: result_hit = 1, err = 1, hit counter incremented, miss counter unchanged.
REQ-024: WAIT_RESP timeout: counter increments each cycle without a result; when it reaches TIMEOUT, set err = 1, result_hit = 0, leave counters unchanged, and -> RESP.
REQ-025: WAIT_CLR: stay until pf_prefetch_hit and pf_prefetch_miss are both low, then -> RESP; no new strobe is issued while either is high.
REQ-026: RESP: ack[cur_core] = 1, resp_hit = result_hit, resp_err = err for one cycle; rr_ptr = (cur_core + 1) mod NUM_CORES; clear err; -> IDLE.
REQ-027: ack, resp_hit and resp_err are 0 in every state other than RESP.
REQ-028: Requester drops req on the edge at which ack is sampled; the arbiter re-evaluates req only in IDLE, one cycle after RESP.
REQ-029: req[cur_core] deasserted mid-transaction is ignored; the transaction completes and ack is still pulsed.
REQ-030: Counters saturate at 2^CNT_W-1, with no wrap.
REQ-031: Minimum latency, IDLE grant to ack: 5 cycles with a 1-cycle prefetcher response and 1-cycle clear.

Reset
REQ-032: rst high forces IDLE asynchronously at any state, including mid-transaction: ack = 0, resp_hit = 0, resp_err = 0, busy = 0, pf_cache_miss = 0, pf_address = 0, rr_ptr = 0, all counters = 0, timeout counter = 0, err = 0.
REQ-033: After rst falls, the first grant occurs no earlier than the first posedge with rst low.

Verification
REQ-034: Single request: req = 4'b0010 with addr 0x0000_1230; prefetcher replies miss -> pf_cache_miss pulses once with pf_address 0x0000_1230; ack = 4'b0010 with resp_hit = 0 and resp_err = 0; miss_count[1] = 1.
REQ-035: Fairness: req = 4'b1111 held, with each core re-requesting after its ack -> grant order 0, 1, 2, 3, 0; each core's count total = 1 after four transactions.
REQ-036: Timeout: prefetcher never responds, TIMEOUT = 15 -> ack with resp_err = 1 and resp_hit = 0 after WAIT_RESP has lasted 15 cycles; counters unchanged.
REQ-037: Protocol violation: hit and miss both high -> resp_hit = 1, resp_err = 1, hit_count incremented.
REQ-038: Saturation: CNT_W = 2, five hits on core 0 -> hit_count[0] = 3.
REQ-039: Reset mid-WAIT_CLR -> next cycle busy = 0, all counters = 0, no ack; the next request is granted normally starting from core 0.
